// File: rtl/uart_pkg.sv
// =============================================================================
// uart_pkg : shared UART FSM encoding, default timing and frame-length helper
// Rev 1.0
// =============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5,
    DONE   = 3'd6
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  // Bit times from the start bit through the last stop/gap bit.
  function automatic int frame_bits(input int data_bits, input int parity,
                                    input int stop_bits, input int gap_bits);
    return 1 + data_bits + parity + stop_bits + gap_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// =============================================================================
// uart_baud_gen : 16-bit bit-period counter with synchronous clear and bit_tick
// Rev 1.0
// =============================================================================
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign bit_tick_o = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_param.sv
// =============================================================================
// uart_tx_param : parametrised UART transmitter, valid/ready in, serial line out
// Optional parity bit when UART_TX_PARITY_EN is defined.  Rev 1.0
// =============================================================================
`default_nettype none

module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (GAP_BITS < 0 || GAP_BITS > 31) begin : g_bad_gap_bits
    $error("uart_tx_param: GAP_BITS must be 0..31");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  localparam logic [4:0] LAST_DATA = 5'(DATA_BITS - 1);
  localparam logic [4:0] LAST_STOP = 5'(STOP_BITS - 1);
  localparam logic [4:0] LAST_GAP  = (GAP_BITS > 0) ? 5'(GAP_BITS - 1) : 5'd0;

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 bit_tick;

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign accept   = tx_valid && tx_ready;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (accept),
    .bit_tick_o(bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= (^tx_data) ^ ODD_BIT;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = tx_data;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 5'd1;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = (GAP_BITS > 0) ? GAP : DONE;
          end
        end
      end
      GAP: begin
        if (bit_tick) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == LAST_GAP) begin
            idx_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level and done pulse are registered from the next state so they
  // stay cycle-aligned with tx_ready.
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state_d == DONE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
// =============================================================================
// tb_uart_tx_param : scoreboard bench for two uart_tx_param configurations
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_param;

  localparam int TIMEOUT = 2000;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // Instance 0: 8N1 at 16 clk/bit. Instance 1: 7 data, 2 stop, 3 gap, odd.
  localparam int CPB_T [2] = '{16, 5};
  localparam int DB_T  [2] = '{8, 7};
  localparam int SB_T  [2] = '{1, 2};
  localparam int GB_T  [2] = '{0, 3};
  localparam int ODD_T [2] = '{0, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_r [2];
  logic       ready_w [2];
  logic       tx_w    [2];
  logic       busy_w  [2];
  logic       done_w  [2];

  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic [9:0]  q0 [$];
  logic [9:0]  q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(
    .CLKS_PER_BIT(CPB_T[0]), .DATA_BITS(DB_T[0]), .STOP_BITS(SB_T[0]),
    .GAP_BITS(GB_T[0]), .PARITY_ODD(ODD_T[0])
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_tx_param #(
    .CLKS_PER_BIT(CPB_T[1]), .DATA_BITS(DB_T[1]), .STOP_BITS(SB_T[1]),
    .GAP_BITS(GB_T[1]), .PARITY_ODD(ODD_T[1])
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
  );

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [8:0] mask_word(input int k, input logic [8:0] w);
    return w & 9'((1 << DB_T[k]) - 1);
  endfunction

  // Expected line level at cycle c of a frame, from the frame layout alone.
  function automatic logic exp_level(input int k, input logic [8:0] w, input int c);
    int b;
    b = c / CPB_T[k];
    if (b == 0) return 1'b0;
    if (b <= DB_T[k]) return w[b-1];
    if (PAR == 1 && b == DB_T[k] + 1) return (^w) ^ (ODD_T[k] != 0);
    return 1'b1;
  endfunction

  task automatic push(input int k, input logic [9:0] e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drive(input int k, input logic [8:0] w, input logic v);
    if (k == 0) data_a = w[7:0];
    else data_b = w[6:0];
    valid_r[k] = v;
  endtask

  // Called at posedge+1. b2b marks a frame that must follow the previous one
  // with exactly two idle-high cycles; keep leaves tx_valid asserted.
  task automatic send(input int k, input logic [8:0] w, input bit b2b, input bit keep);
    int n = 0;
    logic [8:0] m;
    m = mask_word(k, w);
    drive(k, m, 1'b1);
    while (ready_w[k] !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TIMEOUT) begin
      check(1'b0, $sformatf("accept_timeout%0d", k), n, TIMEOUT);
      valid_r[k] = 1'b0;
      return;
    end
    push(k, {b2b, m});
    @(posedge clk); #1;
    check(ready_w[k] === 1'b0 && tx_w[k] === 1'b0, $sformatf("start_latency%0d", k),
          {30'd0, ready_w[k], tx_w[k]}, 0);
    if (!keep) valid_r[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (ready_w[k] !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TIMEOUT) check(1'b0, $sformatf("idle_timeout%0d", k), n, TIMEOUT);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor(input int k);
    logic [9:0]  e;
    int          fl, bad, first_bad, qn;
    bit          aborted;
    bit          have_last = 1'b0;
    int unsigned st;
    int unsigned last_done = 0;
    fl = uart_pkg::frame_bits(DB_T[k], PAR, SB_T[k], GB_T[k]) * CPB_T[k];
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || ready_w[k] !== 1'b0) continue;
      st = cyc;
      qn = (k == 0) ? q0.size() : q1.size();
      check(qn != 0, $sformatf("spurious_frame%0d", k), qn, 1);
      if (qn == 0) begin
        for (int n = 0; n < TIMEOUT && ready_w[k] !== 1'b1; n++) @(negedge clk);
        have_last = 1'b0;
        continue;
      end
      if (k == 0) e = q0.pop_front();
      else e = q1.pop_front();
      if (e[9]) check(have_last && (st - last_done == 2), $sformatf("b2b_spacing%0d", k),
                      int'(st - last_done), 2);
      bad = 0; first_bad = -1; aborted = 1'b0;
      for (int c = 0; c < fl; c++) begin
        if (c != 0) @(negedge clk);
        if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
        if (tx_w[k] !== exp_level(k, e[8:0], c) || ready_w[k] !== 1'b0 ||
            busy_w[k] !== 1'b1 || done_w[k] !== 1'b0) begin
          bad++;
          if (first_bad < 0) first_bad = c;
        end
      end
      if (aborted) begin have_last = 1'b0; continue; end
      check(bad == 0, $sformatf("frame_wave%0d word=%0h first_bad_cycle", k, e[8:0]),
            first_bad, -1);
      @(negedge clk);
      check(done_w[k] === 1'b1 && ready_w[k] === 1'b0 && tx_w[k] === 1'b1,
            $sformatf("done_pulse%0d {done,ready,tx}", k),
            {29'd0, done_w[k], ready_w[k], tx_w[k]}, 5);
      last_done = cyc;
      have_last = 1'b1;
      @(negedge clk);
      if (rst_n === 1'b1)
        check(done_w[k] === 1'b0 && ready_w[k] === 1'b1 && tx_w[k] === 1'b1,
              $sformatf("idle_after_done%0d {done,ready,tx}", k),
              {29'd0, done_w[k], ready_w[k], tx_w[k]}, 3);
    end
  endtask

  task automatic rand_stream(input int k, input int n);
    bit prev_keep = 1'b0;
    bit keep;
    int g;
    for (int i = 0; i < n; i++) begin
      keep = (i < n - 1) && ($urandom_range(0, 2) == 0);
      send(k, 9'($urandom), prev_keep, keep);
      prev_keep = keep;
      if (!keep) begin
        g = $urandom_range(0, 12);
        repeat (g) begin @(posedge clk); #1; end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    valid_r[0] = 1'b0;
    valid_r[1] = 1'b0;
    data_a = '0;
    data_b = '0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      check(tx_w[k] === 1'b1 && ready_w[k] === 1'b1 && busy_w[k] === 1'b0 && done_w[k] === 1'b0,
            $sformatf("reset_state%0d {tx,ready,busy,done}", k),
            {28'd0, tx_w[k], ready_w[k], busy_w[k], done_w[k]}, 12);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 9'h41, 1'b0, 1'b0); wait_idle(0);
    send(1, 9'h55, 1'b0, 1'b0); wait_idle(1);

    send(0, 9'hA5, 1'b0, 1'b1); send(0, 9'h3C, 1'b1, 1'b0); wait_idle(0);
    send(1, 9'h2A, 1'b0, 1'b1); send(1, 9'h13, 1'b1, 1'b0); wait_idle(1);

    // New data and a valid pulse while a frame is in flight must be ignored.
    send(1, 9'h66, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    drive(1, 9'h19, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    valid_r[1] = 1'b0;
    wait_idle(1);

    // Reset in the middle of data bit 3 (cycles 4*CPB+1 .. 5*CPB).
    send(0, 9'h5A, 1'b0, 1'b0);
    repeat (4 * CPB_T[0] + CPB_T[0] / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check(tx_w[0] === 1'b1, "rst_mid_tx", int'(tx_w[0]), 1);
    check(ready_w[0] === 1'b1, "rst_mid_ready", int'(ready_w[0]), 1);
    check(done_w[0] === 1'b0, "rst_mid_done", int'(done_w[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(tx_w[0] === 1'b1 && done_w[0] === 1'b0 && ready_w[0] === 1'b1,
          "post_reset_idle {tx,done,ready}",
          {29'd0, tx_w[0], done_w[0], ready_w[0]}, 5);
    send(0, 9'h0F, 1'b0, 1'b0); wait_idle(0);

    fork
      rand_stream(0, 10);
      rand_stream(1, 16);
    join
    wait_idle(0);
    wait_idle(1);
    check(q0.size() == 0, "queue_drain0", q0.size(), 0);
    check(q1.size() == 0, "queue_drain1", q1.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
